// File: rtl/sid_voice_dca_scheduler.sv
// rtl/sid_voice_dca_scheduler.sv - time-multiplexed voice DCA with one shared 12x8 multiplier
module sid_voice_dca_scheduler #(
    parameter int VOICES = 3,
    parameter int MIX_W  = 12 + $clog2(VOICES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce_1m,
    input  logic [12*VOICES-1:0]  wave_in,
    input  logic [8*VOICES-1:0]   env_in,
    input  logic [VOICES-1:0]     mute,
    input  logic                  overrun_clr,
    output logic [12*VOICES-1:0]  signal_out,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [MIX_W-1:0]  acc;

    logic [11:0]       snap_wave [VOICES];
    logic [7:0]        snap_env  [VOICES];
    logic [VOICES-1:0] snap_mute;
    logic [11:0]       stage     [VOICES];

    logic [11:0]       cur_wave;
    logic [7:0]        cur_env;
    logic              cur_mute;
    logic [19:0]       prod;
    logic [11:0]       amp;
    logic [7:0]        unused_prod_lsbs;

    // Select the snapshot of the voice currently owning the multiplier
    always_comb begin
        cur_wave = '0;
        cur_env  = '0;
        cur_mute = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_wave = snap_wave[i];
                cur_env  = snap_env[i];
                cur_mute = snap_mute[i];
            end
        end
    end

    // Shared multiplier; the envelope is a 0..255/256 gain, so keep the top 12 bits
    assign prod             = {8'd0, cur_wave} * {12'd0, cur_env};
    assign amp              = prod[19:8];
    assign unused_prod_lsbs = prod[7:0];

    assign busy = (state != ST_IDLE);

    // Frame sequencer: snapshot on tick, one voice per clock, then publish
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc       <= '0;
            snap_mute <= '0;
            for (int i = 0; i < VOICES; i++) begin
                snap_wave[i] <= '0;
                snap_env[i]  <= '0;
                stage[i]     <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_1m) begin
                        for (int i = 0; i < VOICES; i++) begin
                            snap_wave[i] <= wave_in[12*i +: 12];
                            snap_env[i]  <= env_in[8*i +: 8];
                        end
                        snap_mute <= mute;
                        idx       <= '0;
                        acc       <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            stage[i] <= amp;
                        end
                    end
                    if (!cur_mute) begin
                        acc <= acc + MIX_W'(amp);
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Publish a coherent frame: all voices and the mix change together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signal_out  <= '0;
            mix_out     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                for (int i = 0; i < VOICES; i++) begin
                    signal_out[12*i +: 12] <= stage[i];
                end
                mix_out <= acc;
            end
        end
    end

    // Sticky overrun: a tick while busy is dropped; a new drop beats a clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ce_1m && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sid_voice_dca_scheduler.sv
// tb/tb_sid_voice_dca_scheduler.sv - randomized self-checking bench for sid_voice_dca_scheduler
module tb_sid_voice_dca_scheduler;

    localparam int V  = 3;
    localparam int MW = 12 + $clog2(V);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ce_1m = 1'b0;
    logic [12*V-1:0] wave_in = '0;
    logic [8*V-1:0]  env_in = '0;
    logic [V-1:0]    mute = '0;
    logic            overrun_clr = 1'b0;
    logic [12*V-1:0] signal_out;
    logic [MW-1:0]   mix_out;
    logic            frame_valid;
    logic            busy;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    sid_voice_dca_scheduler #(.VOICES(V)) dut (
        .clock(clock), .reset(reset), .ce_1m(ce_1m),
        .wave_in(wave_in), .env_in(env_in), .mute(mute),
        .overrun_clr(overrun_clr), .signal_out(signal_out),
        .mix_out(mix_out), .frame_valid(frame_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Reference: each voice is wave*env/256 (floor); mix sums the unmuted voices
    task automatic model(input logic [12*V-1:0] w, input logic [8*V-1:0] e,
                         input logic [V-1:0] m,
                         output logic [12*V-1:0] sig, output logic [MW-1:0] mix);
        int total;
        total = 0;
        sig = '0;
        for (int i = 0; i < V; i++) begin
            int a;
            a = (int'(w[12*i +: 12]) * int'(e[8*i +: 8])) / 256;
            sig[12*i +: 12] = 12'(a);
            if (!m[i]) total += a;
        end
        mix = MW'(total);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one tick and observe ten edges; optionally zero wave_in right after the tick edge
    task automatic do_frame(input logic [12*V-1:0] w, input logic [8*V-1:0] e,
                            input logic [V-1:0] m, input bit clobber,
                            output int lat, output int busy_n, output int fv_n);
        wave_in = w; env_in = e; mute = m; ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        if (clobber) wave_in = '0;
        lat = -1; fv_n = 0; busy_n = busy ? 1 : 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (busy) busy_n++;
            if (frame_valid) begin
                fv_n++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({signal_out, mix_out, frame_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_in: got sig=%h mix=%h fv=%b busy=%b ovr=%b expected all 0",
                     signal_out, mix_out, frame_valid, busy, overrun);
        end
        step();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({signal_out, mix_out, frame_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got sig=%h mix=%h fv=%b busy=%b ovr=%b expected all 0",
                     signal_out, mix_out, frame_valid, busy, overrun);
        end
    endtask

    task automatic test_basic();
        int lat, bn, fvn;
        do_frame({12'h000, 12'h800, 12'hFFF}, {8'h55, 8'h80, 8'hFF}, 3'b000, 1'b0, lat, bn, fvn);
        checks++;
        if (signal_out !== {12'h000, 12'h400, 12'hFEF}) begin
            errors++;
            $display("FAIL basic_sig: got %h expected %h", signal_out, {12'h000, 12'h400, 12'hFEF});
        end
        checks++;
        if (mix_out !== MW'('h13EF)) begin
            errors++;
            $display("FAIL basic_mix: got %h expected 13ef", mix_out);
        end
        checks++;
        if (fvn !== 1 || lat !== 4) begin
            errors++;
            $display("FAIL basic_fv: got pulses=%0d latency=%0d expected 1 and 4", fvn, lat);
        end
        checks++;
        if (bn !== 4) begin
            errors++;
            $display("FAIL basic_busy: got %0d busy cycles expected 4", bn);
        end
    endtask

    task automatic test_mute();
        int lat, bn, fvn;
        do_frame({12'h000, 12'h800, 12'hFFF}, {8'h55, 8'h80, 8'hFF}, 3'b010, 1'b0, lat, bn, fvn);
        checks++;
        if (mix_out !== MW'('h0FEF)) begin
            errors++;
            $display("FAIL mute_mix: got %h expected 0fef", mix_out);
        end
        checks++;
        if (signal_out[23:12] !== 12'h400) begin
            errors++;
            $display("FAIL mute_sig1: got %h expected 400", signal_out[23:12]);
        end
    endtask

    task automatic test_snapshot_hold();
        int lat, bn, fvn;
        do_frame({12'h000, 12'h800, 12'hFFF}, {8'h55, 8'h80, 8'hFF}, 3'b000, 1'b1, lat, bn, fvn);
        checks++;
        if (signal_out !== {12'h000, 12'h400, 12'hFEF} || mix_out !== MW'('h13EF)) begin
            errors++;
            $display("FAIL snapshot_hold: got sig=%h mix=%h expected 000400fef and 13ef",
                     signal_out, mix_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [12*V-1:0] w, es;
        logic [8*V-1:0]  e;
        logic [V-1:0]    m;
        logic [MW-1:0]   em;
        int fv_total, bad_frames, stray;
        logic [11:0] wb;
        logic [7:0]  eb;
        wb = 12'($urandom); eb = 8'($urandom);
        fv_total = 0; bad_frames = 0; stray = 0;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < V; i++) begin
                w[12*i +: 12] = wb + 12'(f * 37 + i * 411);
                e[8*i +: 8]   = eb + 8'(f * 11 + i * 29);
            end
            m = V'(f);
            wave_in = w; env_in = e; mute = m; ce_1m = 1'b1;
            step();
            ce_1m = 1'b0;
            if (frame_valid) stray++;
            for (int k = 1; k <= 4; k++) begin
                step();
                if (frame_valid) begin
                    fv_total++;
                    if (k != 4) stray++;
                end
            end
            model(w, e, m, es, em);
            if (signal_out !== es || mix_out !== em) begin
                bad_frames++;
                $display("FAIL b2b_frame%0d: got sig=%h mix=%h expected sig=%h mix=%h",
                         f, signal_out, mix_out, es, em);
            end
        end
        checks++;
        if (bad_frames != 0) errors++;
        checks++;
        if (fv_total !== 10 || stray !== 0) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d on-time stray=%0d expected 10 and 0", fv_total, stray);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b expected 0", overrun);
        end
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_random();
        logic [12*V-1:0] w, es;
        logic [8*V-1:0]  e;
        logic [V-1:0]    m;
        logic [MW-1:0]   em;
        int lat, bn, fvn;
        for (int r = 0; r < 6; r++) begin
            w = {12'($urandom), 12'($urandom), 12'($urandom)};
            e = 24'($urandom);
            m = V'($urandom);
            if (r == 0) begin
                w = '1; e = '1; m = '0;
            end
            do_frame(w, e, m, 1'b0, lat, bn, fvn);
            model(w, e, m, es, em);
            checks++;
            if (signal_out !== es || mix_out !== em || lat !== 4 || fvn !== 1) begin
                errors++;
                $display("FAIL random%0d: got sig=%h mix=%h lat=%0d fv=%0d expected sig=%h mix=%h lat=4 fv=1",
                         r, signal_out, mix_out, lat, fvn, es, em);
            end
        end
    endtask

    task automatic test_overrun();
        logic [12*V-1:0] w, es;
        logic [8*V-1:0]  e;
        logic [MW-1:0]   em;
        int fvn;
        w = {12'($urandom), 12'($urandom), 12'($urandom)} | {3{12'h800}};
        e = 24'($urandom) | {3{8'h80}};
        wave_in = w; env_in = e; mute = '0; ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        step();
        ce_1m = 1'b1;
        wave_in = ~w;
        env_in = ~e;
        step();
        ce_1m = 1'b0;
        fvn = 0;
        for (int c = 3; c <= 12; c++) begin
            step();
            if (frame_valid) fvn++;
        end
        model(w, e, '0, es, em);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        checks++;
        if (fvn !== 1 || signal_out !== es || mix_out !== em) begin
            errors++;
            $display("FAIL overrun_frame: got fv=%0d sig=%h mix=%h expected 1 %h %h",
                     fvn, signal_out, mix_out, es, em);
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: got %b expected 0", overrun);
        end
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        step();
        ce_1m = 1'b1;
        overrun_clr = 1'b1;
        step();
        ce_1m = 1'b0;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins: got %b expected 1", overrun);
        end
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_reset_mid_frame();
        logic [12*V-1:0] w, es;
        logic [8*V-1:0]  e;
        logic [V-1:0]    m;
        logic [MW-1:0]   em;
        int lat, bn, fvn, fv_seen;
        wave_in = {12'h123, 12'h456, 12'h789}; env_in = {8'h9A, 8'hBC, 8'hDE}; ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({signal_out, mix_out, frame_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL midreset_zero: got sig=%h mix=%h fv=%b busy=%b ovr=%b expected all 0",
                     signal_out, mix_out, frame_valid, busy, overrun);
        end
        fv_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            if (frame_valid) fv_seen++;
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (frame_valid) fv_seen++;
        end
        checks++;
        if (fv_seen !== 0) begin
            errors++;
            $display("FAIL midreset_nofv: got %0d pulses expected 0", fv_seen);
        end
        w = {12'($urandom), 12'($urandom), 12'($urandom)};
        e = 24'($urandom);
        m = V'($urandom);
        do_frame(w, e, m, 1'b0, lat, bn, fvn);
        model(w, e, m, es, em);
        checks++;
        if (signal_out !== es || mix_out !== em || lat !== 4 || fvn !== 1) begin
            errors++;
            $display("FAIL midreset_next: got sig=%h mix=%h lat=%0d fv=%0d expected sig=%h mix=%h lat=4 fv=1",
                     signal_out, mix_out, lat, fvn, es, em);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mute();
        test_snapshot_hold();
        test_back_to_back();
        test_random();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
